comp_accumulate: RTL and testbench
==================================

// Module: comp_accumulate
// PURPOSE
//  Complex accumulator that sits directly downstream of comp_multiply.
//  Consumes a stream of packed complex float products and sums LEN of them into one complex result.
//  Forms the reduction stage of a complex dot-product / correlation datapath.
//  Data format matches comp_multiply: {re, im}, re in the upper half, IEEE754 per half.
// PARAMETERS
//  double  0   0 = single precision (32b halves, 64b word); 1 = double precision (64b halves, 128b word)
//  LEN_W   16  width of the beat-count field
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse; latch len and begin a frame (accepted only in IDLE)
//  len        in   LEN_W   number of products to sum in this frame
//  in_valid   in   1       in_data is valid
//  in_ready   out  1       block accepts in_data this cycle
//  in_data    in   W       product from comp_multiply; W = double ? 128 : 64
//  out_valid  out  1       out_data holds a completed sum
//  out_ready  in   1       consumer accepts out_data
//  out_data   out  W       accumulated complex sum {re, im}
//  busy       out  1       high in ACC or HOLD
// BEHAVIOUR
//  Reset: state = IDLE, acc = +0.0 in both halves, count = 0.
//   Outputs at reset: in_ready = 0, out_valid = 0, out_data = 0, busy = 0.
//  FSM states: IDLE, ACC, HOLD.
//   IDLE -> ACC on start when len != 0.
//     On entry: remaining = len, acc = +0.0.
//   IDLE -> HOLD on start when len == 0.
//     out_data = 0 and out_valid are high on the next cycle.
//   ACC:
//     in_ready = 1.
//     A beat is accepted when in_valid & in_ready. On each accepted beat:
//       acc_re <= fpu_add(acc_re, in_re)
//       acc_im <= fpu_add(acc_im, in_im)
//       remaining decrements.
//     On the beat with remaining == 1 the sum is registered into out_data and state -> HOLD.
//     Latency: out_valid is high the cycle after the last beat is accepted.
//   HOLD:
//     out_valid = 1; out_data is stable and in_ready = 0.
//     out_valid & out_ready -> IDLE; out_valid drops on the next cycle.
//     There is no bypass: a new start cannot be accepted in the same cycle as the output handshake.
//  start is ignored outside IDLE: it does not restart the frame and does not change len.
//  in_valid outside ACC is ignored; no beat is consumed.
//  The adders are combinational fpu_add instances (one per half), each with the double parameter.
//   The result is registered once per accepted beat.
//   Rounding and special values (NaN/Inf/denormals) are those of fpu_add; this block does not inspect them.
//  Asserting rst_n low mid-frame discards the partial sum and the count immediately.
//   The block returns to the reset values above; there is no partial output.
//  len is sampled only on start; changing len during a frame has no effect.
// STRUCTURE
//  Shared package / include:
//   FP_W = double ? 64 : 32; W = 2*FP_W
//   state encoding localparams ST_IDLE, ST_ACC, ST_HOLD
//   helpers to pack and unpack {re, im}, shared with comp_multiply
//  Sub-module: one natural one, comp_add (two fpu_add instances in parallel on the re and im halves).
//   It is reusable by later butterfly stages.
//  The top level holds the FSM, the remaining counter, the acc register and the out register.
// TESTING
//  1. Reset: rst_n=0 -> in_ready=0, out_valid=0, out_data=0, busy=0.
//  2. Basic sum: single precision, start with len=3.
//      Send 3 beats of 64'h3f800000_40000000 (1+2i), back to back.
//      -> out_valid exactly 1 cycle after beat 3, out_data = 64'h40400000_40c00000 (3+6i).
//  3. Back-pressure and gaps: len=2; in_valid toggles 1,0,1 on 0x3f800000_00000000, then out_ready held low 5 cycles.
//      -> out_data = 64'h40000000_00000000 held stable throughout HOLD; in_ready=0 during HOLD.
//  4. Empty frame: start with len=0.
//      -> next cycle out_valid=1 and out_data=0; no input beats are consumed.
//  5. Control while busy: start pulsed mid-frame with len=7 is ignored; reset mid-frame clears.
//      - Frame len=4 with 2 beats sent, then rst_n=0 for 1 cycle.
//      - Then run a fresh len=1 frame with 1+2i.
//      -> out_data = 64'h3f800000_40000000, with no residue from the aborted frame.
//  6. Chained with comp_multiply: feed 2 products of (0.1+0.1i)*(0.1+0.1i).
//      -> out_data im = 0x3d23d70a (0.04); re is +/-0.

Source files
------------

// File: rtl/comp_accumulate_pkg.sv
// Shared types and helpers for the complex accumulate datapath.
// Complex words are {re, im} with re in the upper half; each half is IEEE754.
package comp_accumulate_pkg;

    localparam int unsigned FP_W_SP = 32;
    localparam int unsigned FP_W_DP = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Width of one real/imaginary half.
    function automatic int unsigned fp_width(input bit dbl);
        return dbl ? FP_W_DP : FP_W_SP;
    endfunction

    // Helpers work on the widest word; callers size-cast to their own width.
    function automatic logic [127:0] cplx_pack(input logic [63:0] re, input logic [63:0] im,
                                               input bit dbl);
        return dbl ? {re, im} : {64'd0, re[31:0], im[31:0]};
    endfunction

    function automatic logic [63:0] cplx_re(input logic [127:0] w, input bit dbl);
        return dbl ? w[127:64] : {32'd0, w[63:32]};
    endfunction

    function automatic logic [63:0] cplx_im(input logic [127:0] w, input bit dbl);
        return dbl ? w[63:0] : {32'd0, w[31:0]};
    endfunction

endpackage

// File: rtl/comp_add.sv
// Complex adder: two fpu_add instances side by side on the re and im halves.
module comp_add import comp_accumulate_pkg::*; #(
    parameter bit DOUBLE = 1'b0,
    localparam int unsigned FP_W = fp_width(DOUBLE),
    localparam int unsigned W = 2 * FP_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic [FP_W-1:0] a_re, a_im, b_re, b_im, s_re, s_im;

    assign a_re = FP_W'(cplx_re(128'(a), DOUBLE));
    assign a_im = FP_W'(cplx_im(128'(a), DOUBLE));
    assign b_re = FP_W'(cplx_re(128'(b), DOUBLE));
    assign b_im = FP_W'(cplx_im(128'(b), DOUBLE));

    fpu_add #(.DOUBLE(DOUBLE)) u_add_re (.a(a_re), .b(b_re), .y(s_re));
    fpu_add #(.DOUBLE(DOUBLE)) u_add_im (.a(a_im), .b(b_im), .y(s_im));

    assign sum = W'(cplx_pack(64'(s_re), 64'(s_im), DOUBLE));

endmodule

// File: rtl/fpu_add.sv
// Combinational IEEE754 adder, round-to-nearest-even, gradual underflow.
module fpu_add #(
    parameter bit DOUBLE = 1'b0,
    localparam int unsigned FP_W = DOUBLE ? 64 : 32
) (
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] y
);
    localparam int unsigned EW  = DOUBLE ? 11 : 8;
    localparam int unsigned MW  = FP_W - EW - 1;
    localparam int unsigned SW  = MW + 5;  // carry, hidden, fraction, guard, round, sticky
    localparam int unsigned EW1 = EW + 1;
    localparam int unsigned MW2 = MW + 2;
    localparam logic [EW-1:0] EXP_MAX = '1;

    logic          sa, sb, sx, eff_sub, round_up, found;
    logic [EW-1:0] exa, exb, ea, eb, ex, ey;
    logic [MW:0]   ma, mb, mx, my;
    logic          a_nan, b_nan, a_inf, b_inf;
    logic [SW-1:0] ax, ay_full, ay, mask, sum;
    logic [SW-2:0] norm;
    logic [EW:0]   e_res;
    logic [MW+1:0] mant_r;
    int unsigned   diff, lz, shamt;

    assign sa    = a[FP_W-1];
    assign sb    = b[FP_W-1];
    assign exa   = a[FP_W-2 -: EW];
    assign exb   = b[FP_W-2 -: EW];
    // Denormals behave as exponent 1 with a clear hidden bit.
    assign ea    = (exa == '0) ? EW'(1) : exa;
    assign eb    = (exb == '0) ? EW'(1) : exb;
    assign ma    = {exa != '0, a[MW-1:0]};
    assign mb    = {exb != '0, b[MW-1:0]};
    assign a_nan = (exa == EXP_MAX) && (a[MW-1:0] != '0);
    assign b_nan = (exb == EXP_MAX) && (b[MW-1:0] != '0);
    assign a_inf = (exa == EXP_MAX) && (a[MW-1:0] == '0);
    assign b_inf = (exb == EXP_MAX) && (b[MW-1:0] == '0);

    // Align, add/subtract, normalise, round, then override with special cases.
    always_comb begin
        sx = sa; ex = ea; ey = eb; mx = ma; my = mb;
        if ({eb, mb} > {ea, ma}) begin
            sx = sb; ex = eb; ey = ea; mx = mb; my = ma;
        end
        eff_sub = sa ^ sb;
        diff    = 32'(ex) - 32'(ey);
        ax      = {1'b0, mx, 3'b000};
        ay_full = {1'b0, my, 3'b000};
        mask    = '0;
        ay      = '0;
        if (diff >= SW) begin
            ay = SW'(my != '0);
        end else begin
            mask  = (SW'(1) << diff) - SW'(1);
            ay    = ay_full >> diff;
            ay[0] = ay[0] | (|(ay_full & mask));
        end
        sum = eff_sub ? ax - ay : ax + ay;

        lz    = 0;
        found = 1'b0;
        for (int i = SW - 2; i >= 0; i--) begin
            if (!found) begin
                if (sum[i]) found = 1'b1;
                else        lz = lz + 1;
            end
        end

        shamt = 0;
        if (sum[SW-1]) begin
            norm  = {sum[SW-1:2], sum[1] | sum[0]};
            e_res = {1'b0, ex} + EW1'(1);
        end else begin
            // Never shift below the minimum exponent; that leaves a denormal.
            shamt = (lz < 32'(ex) - 1) ? lz : 32'(ex) - 1;
            norm  = sum[SW-2:0] << shamt;
            e_res = {1'b0, ex} - EW1'(shamt);
            if (!norm[SW-2]) e_res = '0;
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[SW-2:3]} + MW2'(round_up);
        if (mant_r[MW+1])                     e_res = e_res + EW1'(1);
        else if (e_res == '0 && mant_r[MW])   e_res = EW1'(1);

        y = {sx, e_res[EW-1:0], mant_r[MW-1:0]};
        if (e_res >= {1'b0, EXP_MAX}) y = {sx, EXP_MAX, {MW{1'b0}}};
        // Exact cancellation yields +0 unless both operands are negative.
        if (sum == '0) y = {sa & sb, {(FP_W-1){1'b0}}};
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            y = {1'b0, EXP_MAX, 1'b1, {(MW-1){1'b0}}};
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end
    end

endmodule

// File: rtl/comp_accumulate.sv
// Complex accumulator: sums len packed complex products into one {re, im} result.
module comp_accumulate import comp_accumulate_pkg::*; #(
    parameter bit DOUBLE = 1'b0,
    parameter int unsigned LEN_W = 16,
    localparam int unsigned W = 2 * fp_width(DOUBLE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [W-1:0]     acc_q, acc_d, out_q, out_d, sum;
    logic             beat;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_q;
    assign beat      = in_valid & in_ready;

    comp_add #(.DOUBLE(DOUBLE)) u_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (sum)
    );

    // State, counter and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
        end
    end

    // Frame control: latch len on start, accumulate accepted beats, hold the result.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        out_d       = out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = len;
                    acc_d       = '0;
                    if (len == '0) begin
                        out_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (beat) begin
                    acc_d       = sum;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        out_d   = sum;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_comp_accumulate.sv
// Self-checking bench for comp_accumulate (single precision).
module tb_comp_accumulate;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] len;
    logic [63:0] in_data, out_data;
    logic [63:0] vec [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    comp_accumulate #(.DOUBLE(1'b0), .LEN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference float arithmetic via real: a single-precision value widened to double.
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return $bitstoreal({f[31], 63'd0});
        e = 11'(int'(f[30:23]) + 896);
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    // Round a double back to single precision, nearest-even (normal range only).
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        m = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return r2f(f2r(x) + f2r(y));
    endfunction

    // Model: phase 0 waiting for start, 1 collecting beats, 2 presenting a result.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_re    = '0;
    logic [31:0] m_im    = '0;
    logic [63:0] m_out   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_re    <= '0;
            m_im    <= '0;
            m_out   <= '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_re    <= '0;
                m_im    <= '0;
                m_left  <= int'(len);
                m_out   <= (len == 16'd0) ? 64'd0 : m_out;
                m_phase <= (len == 16'd0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_re   <= fadd(m_re, in_data[63:32]);
                m_im   <= fadd(m_im, in_data[31:0]);
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_out   <= {fadd(m_re, in_data[63:32]), fadd(m_im, in_data[31:0])};
                    m_phase <= 2;
                end
            end
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("in_ready", 128'(in_ready), 128'(m_phase == 1));
        check("out_valid", 128'(out_valid), 128'(m_phase == 2));
        check("busy", 128'(busy), 128'(m_phase != 0));
        if (m_phase == 2) check("out_data", 128'(out_data), 128'(m_out));
        if (!rst_n) check("reset out_data", 128'(out_data), 128'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        cyc();
        start = 1'b0;
    endtask

    // Back-to-back frame of n beats from vec; out_valid must rise the next cycle.
    task automatic send_frame(input int n);
        pulse_start(16'(n));
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data = vec[i];
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("latency out_valid", 128'(out_valid), 128'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid after handshake", 128'(out_valid), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", 128'(in_ready), 128'd0);
        check("rst out_valid", 128'(out_valid), 128'd0);
        check("rst out_data", 128'(out_data), 128'd0);
        check("rst busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // 3 x (1+2i) = 3+6i
        vec[0] = 64'h3f800000_40000000; vec[1] = vec[0]; vec[2] = vec[0];
        send_frame(3);
        check("basic sum", 128'(out_data), 128'(64'h40400000_40c00000));
        drain();

        // Gapped input then a long stall; a start during HOLD must be ignored.
        pulse_start(16'd2);
        in_data = 64'h3f800000_00000000;
        in_valid = 1'b1; cyc();
        in_valid = 1'b0; cyc();
        in_valid = 1'b1; cyc();
        in_valid = 1'b0;
        start = 1'b1; len = 16'd5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold out_valid", 128'(out_valid), 128'd1);
            check("hold in_ready", 128'(in_ready), 128'd0);
            check("hold out_data", 128'(out_data), 128'(64'h40000000_00000000));
            cyc();
            start = 1'b0;
        end
        drain();
        check("idle after hold", 128'(busy), 128'd0);

        // Empty frame: result is zero next cycle and offered beats are not taken.
        in_valid = 1'b1;
        in_data  = 64'h3f800000_40000000;
        pulse_start(16'd0);
        @(negedge clk);
        check("empty out_valid", 128'(out_valid), 128'd1);
        check("empty out_data", 128'(out_data), 128'd0);
        check("empty in_ready", 128'(in_ready), 128'd0);
        drain();
        in_valid = 1'b0;

        // Mid-frame start ignored, then a reset abort, then a clean 1-beat frame.
        pulse_start(16'd4);
        in_valid = 1'b1;
        in_data  = 64'h3f800000_40000000;
        cyc();
        start = 1'b1; len = 16'd7;
        cyc();
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("still accumulating", 128'(in_ready), 128'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort busy", 128'(busy), 128'd0);
        check("abort out_data", 128'(out_data), 128'd0);
        rst_n = 1'b1;
        vec[0] = 64'h3f800000_40000000;
        send_frame(1);
        check("no residue", 128'(out_data), 128'(64'h3f800000_40000000));
        drain();

        // Two products of (0.1+0.1i)^2: re 0, im 0.02 each.
        vec[0] = 64'h00000000_3ca3d70a; vec[1] = vec[0];
        send_frame(2);
        check("chain im", 128'(out_data[31:0]), 128'(32'h3d23d70a));
        check("chain re zero", 128'(out_data[62:32]), 128'd0);
        drain();

        // Mixed signs with exact cancellation in im: 0.75 + 0i.
        vec[0] = 64'h3f800000_40000000;
        vec[1] = 64'hbf000000_c0400000;
        vec[2] = 64'h3e800000_3f800000;
        send_frame(3);
        check("mixed signs", 128'(out_data), 128'(64'h3f400000_00000000));
        drain();

        // Inexact sums; checked against the model only.
        vec[0] = 64'h3dcccccd_3e4ccccd;
        vec[1] = 64'h3e4ccccd_40490fdb;
        vec[2] = 64'h40490fdb_c2c80000;
        vec[3] = 64'hc2c80000_3dcccccd;
        send_frame(4);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
